// File: rtl/dmem_arbiter.sv
// Single-port data-memory controller: round-robin sharing between the CPU load/store path
// and a debug/loader port, plus a zero-fill sweep after reset or on clr_start.
module dmem_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wd,
  output logic [WIDTH-1:0] cpu_rd,
  output logic             cpu_stall,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [WIDTH-1:0] dbg_addr,
  input  logic [WIDTH-1:0] dbg_wd,
  output logic [WIDTH-1:0] dbg_rd,
  output logic             dbg_ack,
  input  logic             clr_start,
  output logic             busy,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd
);

  localparam int CW = $clog2(DEPTH);

  typedef enum logic {CLEAR, ARB} state_e;
  typedef enum logic {GNT_CPU = 1'b0, GNT_DBG = 1'b1} master_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   clr_cnt_q, clr_cnt_d;
  master_e         last_gnt_q, last_gnt_d;
  logic            gnt_cpu, gnt_dbg;

  // On a tie the master that was not served last wins.
  always_comb begin
    gnt_cpu = 1'b0;
    gnt_dbg = 1'b0;
    if (state_q == ARB) begin
      gnt_cpu = cpu_req && (!dbg_req || last_gnt_q == GNT_DBG);
      gnt_dbg = dbg_req && (!cpu_req || last_gnt_q == GNT_CPU);
    end
  end

  // NOTE: every output gets a default first so no path through this block infers a latch.
  always_comb begin
    cpu_rd    = mem_rd;
    dbg_rd    = mem_rd;
    busy      = 1'b1;
    cpu_stall = cpu_req;
    dbg_ack   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wd    = cpu_wd;
    if (state_q == CLEAR) begin
      // NOTE: rst_n gates the write enable directly so no write can land while reset is held,
      // even though the async reset already forces state_q to CLEAR.
      mem_we   = rst_n;
      mem_addr = WIDTH'({clr_cnt_q, 2'b00});
      mem_wd   = '0;
    end else begin
      busy      = 1'b0;
      cpu_stall = cpu_req && !gnt_cpu;
      dbg_ack   = gnt_dbg;
      if (gnt_dbg) begin
        mem_we   = dbg_we;
        mem_addr = dbg_addr;
        mem_wd   = dbg_wd;
      end else if (gnt_cpu) begin
        mem_we   = cpu_we;
        mem_addr = cpu_addr;
        mem_wd   = cpu_wd;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + CW'(1);
        if (clr_cnt_q == CW'(DEPTH - 1)) begin
          state_d   = ARB;
          clr_cnt_d = '0;
        end
      end
      ARB: begin
        if (gnt_cpu)      last_gnt_d = GNT_CPU;
        else if (gnt_dbg) last_gnt_d = GNT_DBG;
        if (clr_start) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_cnt_q  <= '0;
      last_gnt_q <= GNT_DBG;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port access controller for the data memory of the single-cycle RISC-V core. It shares the memory's one read/write port between the CPU load/store path and a debug/loader port, using round-robin arbitration on contention. It also runs a synthesizable zero-fill sweep after reset or on command, so the memory needs no simulation-only initialisation. The block sits between the CPU/debug masters and the data memory, whose port is: asynchronous read, write on the clock edge, word address = addr[$clog2(DEPTH)+1:2].

## Interface
Parameters:
- WIDTH, 32, data and byte-address width
- DEPTH, 1024, memory depth in words; the clear sweep covers 0..DEPTH-1

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request (load or store) this cycle
- cpu_we  in  1  CPU store when 1, load when 0
- cpu_addr  in  WIDTH  CPU byte address
- cpu_wd  in  WIDTH  CPU store data
- cpu_rd  out  WIDTH  CPU load data, valid when cpu_req=1 and cpu_stall=0
- cpu_stall  out  1  CPU access not served this cycle; CPU holds PC and request
- dbg_req  in  1  debug/loader request; held stable until dbg_ack
- dbg_we  in  1  debug write when 1
- dbg_addr  in  WIDTH  debug byte address
- dbg_wd  in  WIDTH  debug write data
- dbg_rd  out  WIDTH  debug read data, valid in the dbg_ack cycle
- dbg_ack  out  1  debug access served this cycle
- clr_start  in  1  request a new zero-fill sweep
- busy  out  1  clear sweep in progress
- mem_we  out  1  to memory write enable
- mem_addr  out  WIDTH  to memory byte address
- mem_wd  out  WIDTH  to memory write data
- mem_rd  in  WIDTH  from memory read data

## Operation
- States: CLEAR and ARB. Registers: state, clr_cnt[$clog2(DEPTH)-1:0], last_gnt (0 = CPU, 1 = debug).
- Reset state: state=CLEAR, clr_cnt=0, last_gnt=1, so the CPU wins the first tie.
- While rst_n is low, outputs are mem_we=0, dbg_ack=0, busy=1, cpu_stall=cpu_req. These hold combinationally, independent of clk.
- CLEAR:
  - mem_we=1, mem_addr={clr_cnt,2'b00} zero-extended to WIDTH, mem_wd=0, busy=1.
  - cpu_stall=cpu_req, dbg_ack=0.
  - clr_cnt increments each cycle. When clr_cnt=DEPTH-1, the next state is ARB and clr_cnt returns to 0.
  - clr_start is ignored in this state.
- ARB grant rules (combinational):
  - Only cpu_req → CPU. Only dbg_req → debug. Neither → no grant, mem_we=0.
  - Both → the master not in last_gnt is granted.
  - last_gnt updates on the edge to whichever master was granted. It is unchanged when there is no grant.
- Granted CPU: mem_* = cpu_*; cpu_rd=mem_rd; cpu_stall=0.
- Granted debug: mem_* = dbg_*; dbg_rd=mem_rd; dbg_ack=1.
- Loser: cpu_stall=1 or dbg_ack=0.
- Addresses pass through unmodified. Range folding and misalignment are the memory's concern.
- cpu_rd and dbg_rd track mem_rd at all times, but are meaningful only when served.
- clr_start=1 in ARB:
  - The current cycle's grant completes normally.
  - Next state is CLEAR with clr_cnt=0.
  - last_gnt is preserved.

## Timing
- Cycle 0 is the first rising edge after rst_n deasserts. Clear writes land at edges 0..DEPTH-1. busy=0 and ARB hold from the cycle after edge DEPTH-1. A full sweep is DEPTH cycles.
- Served accesses have zero latency:
  - Read data is valid in the grant cycle.
  - A write commits at the edge ending the grant cycle, and a read in the following cycle returns the new value.
- Under continuous contention each master is served every other cycle. Maximum wait is 1 cycle.
- Debug handshake: hold dbg_req/addr/we/wd until dbg_ack=1. Dropping the request or changing any field before ack is illegal.
- Reset asserted mid-sweep or mid-access aborts immediately. The sweep restarts from address 0 after release.
- No write from an in-flight access occurs while rst_n=0.

## Test plan
- Reset release, DEPTH=16, no requests → busy=1 for exactly 16 cycles; mem_we=1, mem_wd=0 with mem_addr 0x0,0x4..0x3C; busy=0 in cycle 16.
- After clear, CPU store 0xDEADBEEF @0x40, then load @0x40 → cpu_stall=0 both cycles; cpu_rd=0xDEADBEEF on the load.
- cpu_req and dbg_req both held 4 cycles → grants CPU,dbg,CPU,dbg; cpu_stall=0,1,0,1; dbg_ack=0,1,0,1.
- Debug write 0x12345678 @0x8 with cpu idle → dbg_ack=1 in the same cycle; a later debug read @0x8 returns dbg_rd=0x12345678.
- clr_start pulsed with a concurrent CPU store 0xA5 @0x4 → the store completes (cpu_stall=0). The next DEPTH cycles have busy=1 and stall any cpu_req. A subsequent read of @0x4 returns 0.
- rst_n pulsed low at sweep step 5 with cpu_req=1 → mem_we=0 and cpu_stall=1 immediately; after release the sweep restarts at mem_addr 0x0 and busy lasts a full DEPTH cycles.
